// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - single-lane parking barrier controller with occupancy tracking
//
// Purpose: arbitrates entry/exit loop requests onto one barrier, tracks the
// number of cars inside, and closes an abandoned opening after a timeout.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   entry_req         level request from the entry loop sensor
//   exit_req          level request from the exit loop sensor
//   sensor_pass       1-cycle pulse: a car has cleared the open barrier
//   parking_capacity  total number of spaces (quasi-static)
//   gate_open         registered barrier-open command
//   gate_dir          registered direction of the barrier (0 entry, 1 exit)
//   occupancy         registered count of cars inside
//   free_spaces       capacity minus occupancy, floored at 0
//   full              occupancy has reached capacity
//   entry_denied      1-cycle pulse for a refused entry
//   timeout           1-cycle pulse for an abandoned opening
`timescale 1ns/1ps

module parking_gate_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic       sensor_pass,
  input  logic [7:0] parking_capacity,
  output logic       gate_open,
  output logic       gate_dir,
  output logic [7:0] occupancy,
  output logic [7:0] free_spaces,
  output logic       full,
  output logic       entry_denied,
  output logic       timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSE} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          last_grant;  // 0 = entry was granted last, 1 = exit
  logic          entry_ok;
  logic          exit_ok;
  logic          grant_exit;

  assign full        = (occupancy >= parking_capacity);
  // When full, capacity <= occupancy, so the subtraction would underflow.
  assign free_spaces = full ? 8'd0 : (parking_capacity - occupancy);

  always_comb begin
    entry_ok   = entry_req && !full;
    exit_ok    = exit_req && (occupancy != 8'd0);
    // On a tie, grant the direction that did not win last time.
    grant_exit = exit_ok && (!entry_ok || !last_grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gate_open    <= 1'b0;
      gate_dir     <= 1'b0;
      occupancy    <= 8'd0;
      wait_cnt     <= '0;
      last_grant   <= 1'b0;
      entry_denied <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      entry_denied <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (entry_ok || exit_ok) begin
            state      <= grant_exit ? OPEN_OUT : OPEN_IN;
            gate_open  <= 1'b1;
            gate_dir   <= grant_exit;
            last_grant <= grant_exit;
          end else if (entry_req) begin
            // entry_req without eligibility here can only mean the lot is full.
            entry_denied <= 1'b1;
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (sensor_pass) begin
            if (state == OPEN_IN) begin
              if (occupancy != 8'hFF) occupancy <= occupancy + 8'd1;
            end else begin
              if (occupancy != 8'd0) occupancy <= occupancy - 8'd1;
            end
            state     <= CLOSE;
            gate_open <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= CLOSE;
            gate_open <= 1'b0;
            timeout   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        CLOSE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst, with every register updating on the rising edge of clk.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of cycles the gate stays open waiting for a car.
REQ-003 Port clk  input  1  SHALL be the system clock.
REQ-004 Port rst  input  1  SHALL be the synchronous active-high reset.
REQ-005 Port entry_req  input  1  SHALL be a level request from the entry loop sensor.
REQ-006 Port exit_req  input  1  SHALL be a level request from the exit loop sensor.
REQ-007 Port sensor_pass  input  1  SHALL be a 1-cycle pulse meaning a car has cleared the open barrier.
REQ-008 Port parking_capacity  input  8  SHALL be the total number of spaces, quasi-static.
REQ-009 Port gate_open  output  1  SHALL be the registered barrier-open command.
REQ-010 Port gate_dir  output  1  SHALL be the registered direction of the open barrier: 0 = entry, 1 = exit.
REQ-011 Port occupancy  output  8  SHALL be the registered count of cars inside.
REQ-012 Port free_spaces  output  8  SHALL be parking_capacity minus occupancy, saturated at 0.
REQ-013 Port full  output  1  SHALL be 1 when occupancy >= parking_capacity.
REQ-014 Port entry_denied  output  1  SHALL be a registered 1-cycle pulse for a refused entry.
REQ-015 Port timeout  output  1  SHALL be a registered 1-cycle pulse for an abandoned gate opening.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, OPEN_IN, OPEN_OUT and CLOSE.
REQ-017 In IDLE, entry SHALL be eligible when entry_req=1 and full=0, and exit SHALL be eligible when exit_req=1 and occupancy!=0.
REQ-018 When only entry is eligible in IDLE, the FSM SHALL go to OPEN_IN.
REQ-019 When only exit is eligible in IDLE, the FSM SHALL go to OPEN_OUT.
REQ-020 When both are eligible in IDLE, the FSM SHALL grant the direction opposite to last_grant, then update last_grant; last_grant SHALL reset to entry, so the first tie goes to exit.
REQ-021 A request sampled in IDLE at cycle n SHALL produce gate_open=1 with the correct gate_dir at cycle n+1.
REQ-022 In OPEN_IN or OPEN_OUT, gate_open SHALL be 1 and a wait counter SHALL increment every cycle, starting from 0 on entry to the state.
REQ-023 sensor_pass in OPEN_IN SHALL increment occupancy by 1 (saturating at 255) and move the FSM to CLOSE.
REQ-024 sensor_pass in OPEN_OUT SHALL decrement occupancy by 1 (saturating at 0) and move the FSM to CLOSE.
REQ-025 If the wait counter reaches TIMEOUT_CYCLES-1 without sensor_pass, the FSM SHALL go to CLOSE with occupancy unchanged and SHALL pulse timeout for 1 cycle.
REQ-026 If sensor_pass coincides with the timeout cycle, the pass SHALL win: occupancy updates and timeout is not pulsed.
REQ-027 CLOSE SHALL last exactly 1 cycle with gate_open=0, then return to IDLE; requests and sensor_pass SHALL be ignored in CLOSE.
REQ-028 sensor_pass SHALL be ignored in IDLE and in CLOSE.
REQ-029 entry_req=1 in IDLE with full=1 and no exit grant that cycle SHALL pulse entry_denied at n+1, repeating every IDLE cycle the condition holds.
REQ-030 full and free_spaces SHALL be combinational from occupancy and parking_capacity.
REQ-031 free_spaces SHALL be 0 when parking_capacity < occupancy (capacity lowered at run time).
REQ-032 parking_capacity=0 SHALL make full=1 permanently, so entry is never granted.
REQ-033 gate_dir SHALL hold its last value while gate_open=0.

Reset
REQ-034 rst=1 at any rising edge, including mid-opening, SHALL on that edge force: state IDLE, gate_open=0, gate_dir=0, occupancy=0, wait counter=0, last_grant=entry, entry_denied=0, timeout=0.
REQ-035 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-036 Scenario: reset; parking_capacity=2; entry_req pulse then sensor_pass at 3 cycles later, repeated twice -> occupancy=2, full=1, free_spaces=0; a third entry_req -> entry_denied pulse and gate_open stays 0.
REQ-037 Scenario: occupancy=1; entry_req=1 and exit_req=1 in the same cycle -> OPEN_OUT first; after sensor_pass and CLOSE, OPEN_IN is granted; final occupancy=1.
REQ-038 Scenario: entry grant with no sensor_pass -> gate_open high for exactly 16 cycles, then timeout pulse, CLOSE, occupancy unchanged.
REQ-039 Scenario: exit_req with occupancy=0 -> no grant, gate_open stays 0; sensor_pass in IDLE -> occupancy unchanged.
REQ-040 Scenario: rst asserted while OPEN_IN -> next cycle gate_open=0 and occupancy=0; parking_capacity changed from 5 to 1 with occupancy=3 -> full=1 and free_spaces=0.
